rts_signature_checker: RTL and testbench

- Downstream consumer of the RTS BIST controller; sits beside the CUT's response path.
- Compacts one CUT response word into a multiple-input signature register (MISR) each cycle the controller pulses its MISR enable.
- Counts the compacted rounds. When the controller asserts done, compares the final signature and round count against golden values.
- Presents a sticky pass/fail result through a valid/ack handshake to the test access logic.

---
 rtl/rts_bist_pkg.sv | 27 ++
 rtl/rts_signature_checker_if.sv | 27 ++
 rtl/rts_misr.sv | 23 ++
 rtl/rts_signature_checker.sv | 88 ++++++++
 tb/tb_rts_signature_checker.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/rts_bist_pkg.sv
// rtl/rts_bist_pkg.sv - shared RTS BIST state encoding and default MISR polynomials
package rts_bist_pkg;

    localparam logic [1:0] ST_COMPACT = 2'd0;
    localparam logic [1:0] ST_COMPARE = 2'd1;
    localparam logic [1:0] ST_REPORT  = 2'd2;
    localparam logic [1:0] ST_HOLD    = 2'd3;

    typedef enum logic [1:0] {
        COMPACT = ST_COMPACT,
        COMPARE = ST_COMPARE,
        REPORT  = ST_REPORT,
        HOLD    = ST_HOLD
    } rtsState_t;

    // Feedback taps per signature width; x^width is implicit.
    function automatic logic [31:0] defaultPoly(input int width);
        case (width)
            4:       return 32'h0000_0003;
            8:       return 32'h0000_001D;
            16:      return 32'h0000_002D;
            32:      return 32'h0000_00AF;
            default: return 32'h0000_0003;
        endcase
    endfunction

endpackage

// File: rtl/rts_signature_checker_if.sv
// rtl/rts_signature_checker_if.sv - controller/CUT side and result side of the signature checker
interface rts_signature_checker_if #(
    parameter int WIDTH = 16,
    parameter int CW    = 6
);
    logic             misr_en;
    logic [WIDTH-1:0] resp;
    logic             done_in;
    logic             clear;
    logic             result_ack;
    logic [WIDTH-1:0] signature;
    logic [CW-1:0]    round_count;
    logic             busy;
    logic             result_valid;
    logic             pass;
    logic             fail;

    modport master (
        output misr_en, resp, done_in, clear, result_ack,
        input  signature, round_count, busy, result_valid, pass, fail
    );

    modport slave (
        input  misr_en, resp, done_in, clear, result_ack,
        output signature, round_count, busy, result_valid, pass, fail
    );
endinterface

// File: rtl/rts_misr.sv
// rtl/rts_misr.sv - multiple-input signature register, shared with the SISA path
module rts_misr
    import rts_bist_pkg::*;
#(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] POLY  = WIDTH'(defaultPoly(WIDTH)),
    parameter logic [WIDTH-1:0] SEED  = '0
) (
    input  logic             clk,
    input  logic             rstIn_n,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] resp,
    output logic [WIDTH-1:0] sig
);
    always_ff @(posedge clk) begin
        if (!rstIn_n || clr) begin
            sig <= SEED;
        end else if (en) begin
            sig <= ({sig[WIDTH-2:0], 1'b0} ^ (sig[WIDTH-1] ? POLY : '0)) ^ resp;
        end
    end
endmodule

// File: rtl/rts_signature_checker.sv
// rtl/rts_signature_checker.sv - compacts CUT responses and reports a sticky golden-signature verdict
module rts_signature_checker
    import rts_bist_pkg::*;
#(
    parameter int               WIDTH      = 16,
    parameter logic [WIDTH-1:0] POLY       = WIDTH'(defaultPoly(WIDTH)),
    parameter logic [WIDTH-1:0] SEED       = '0,
    parameter logic [WIDTH-1:0] GOLDEN     = '0,
    parameter int               NUM_ROUNDS = 50
) (
    input logic                   clk,
    input logic                   rstIn_n,
    rts_signature_checker_if.slave bus
);
    localparam int            CW         = $clog2(NUM_ROUNDS + 2);
    localparam logic [CW-1:0] ROUNDS_EXP = CW'(NUM_ROUNDS);
    // One past the expected count: once reached, the compare cannot match.
    localparam logic [CW-1:0] ROUNDS_SAT = CW'(NUM_ROUNDS + 1);

    rtsState_t        state, stateNext;
    logic [CW-1:0]    roundCount;
    logic [WIDTH-1:0] sig;
    logic             compactEn;
    logic             match;
    logic             passQ, failQ;

    assign compactEn = bus.misr_en && (state == COMPACT);
    assign match     = (sig == GOLDEN) && (roundCount == ROUNDS_EXP);

    rts_misr #(
        .WIDTH (WIDTH),
        .POLY  (POLY),
        .SEED  (SEED)
    ) u_misr (
        .clk     (clk),
        .rstIn_n (rstIn_n),
        .en      (compactEn),
        .clr     (bus.clear),
        .resp    (bus.resp),
        .sig     (sig)
    );

    always_ff @(posedge clk) begin
        if (!rstIn_n) begin
            state      <= COMPACT;
            roundCount <= '0;
            passQ      <= 1'b0;
            failQ      <= 1'b0;
        end else begin
            state <= stateNext;
            if (bus.clear) begin
                roundCount <= '0;
                passQ      <= 1'b0;
                failQ      <= 1'b0;
            end else begin
                if (compactEn && roundCount != ROUNDS_SAT) begin
                    roundCount <= roundCount + 1'b1;
                end
                if (state == COMPARE) begin
                    passQ <= match;
                    failQ <= ~match;
                end
            end
        end
    end

    always_comb begin
        stateNext = state;
        if (bus.clear) begin
            stateNext = COMPACT;
        end else begin
            case (state)
                COMPACT: if (bus.done_in) stateNext = COMPARE;
                COMPARE: stateNext = REPORT;
                REPORT:  if (bus.result_ack) stateNext = HOLD;
                HOLD:    stateNext = HOLD;
                default: stateNext = COMPACT;
            endcase
        end
    end

    assign bus.signature    = sig;
    assign bus.round_count  = roundCount;
    assign bus.busy         = (state == COMPACT) || (state == COMPARE);
    assign bus.result_valid = (state == REPORT);
    assign bus.pass         = passQ;
    assign bus.fail         = failQ;
endmodule

// File: tb/tb_rts_signature_checker.sv
// tb/tb_rts_signature_checker.sv - three checkers (GOLDEN 7/6/A) against a behavioural model
module tb_rts_signature_checker;
    localparam int W  = 4;
    localparam int CW = 3;
    localparam int N  = 3;
    localparam int ND = 3;

    logic clk = 1'b0;
    logic rstN;
    always #5 clk = ~clk;

    logic         enV[ND];
    logic [W-1:0] respV[ND];
    logic         doneV[ND], ackV[ND], clrV[ND];

    logic [W-1:0]  dSig[ND];
    logic [CW-1:0] dCnt[ND];
    logic          dBusy[ND], dValid[ND], dPass[ND], dFail[ND];

    for (genvar g = 0; g < ND; g++) begin : gen_dut
        rts_signature_checker_if #(.WIDTH(W), .CW(CW)) bus ();
        assign bus.misr_en    = enV[g];
        assign bus.resp       = respV[g];
        assign bus.done_in    = doneV[g];
        assign bus.clear      = clrV[g];
        assign bus.result_ack = ackV[g];
        assign dSig[g]   = bus.signature;
        assign dCnt[g]   = bus.round_count;
        assign dBusy[g]  = bus.busy;
        assign dValid[g] = bus.result_valid;
        assign dPass[g]  = bus.pass;
        assign dFail[g]  = bus.fail;

        rts_signature_checker #(
            .WIDTH      (W),
            .POLY       (4'h3),
            .SEED       (4'h0),
            .GOLDEN     (g == 0 ? 4'h7 : (g == 1 ? 4'h6 : 4'hA)),
            .NUM_ROUNDS (N)
        ) dut (
            .clk     (clk),
            .rstIn_n (rstN),
            .bus     (bus)
        );
    end

    int tests = 0;
    int failures = 0;
    bit checkEn = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int golden(input int d);
        return d == 0 ? 7 : (d == 1 ? 6 : 10);
    endfunction

    // Signature polynomial x^4 + x + 1 written as multiply-by-x modulo 16.
    function automatic int misrStep(input int s, input int r);
        int t;
        t = (s * 2) % 16;
        if (s >= 8) t = t ^ 3;
        return t ^ r;
    endfunction

    int mSig[ND], mCnt[ND];
    bit mCompacting[ND], mCmpDue[ND], mValid[ND], mPass[ND], mFail[ND];

    always @(posedge clk) begin
        for (int d = 0; d < ND; d++) begin
            if (!rstN || clrV[d]) begin
                mSig[d] = 0; mCnt[d] = 0; mCompacting[d] = 1; mCmpDue[d] = 0;
                mValid[d] = 0; mPass[d] = 0; mFail[d] = 0;
            end else if (mCompacting[d]) begin
                if (enV[d]) begin
                    mSig[d] = misrStep(mSig[d], int'(respV[d]));
                    if (mCnt[d] < N + 1) mCnt[d]++;
                end
                if (doneV[d]) begin
                    mCompacting[d] = 0;
                    mCmpDue[d] = 1;
                end
            end else if (mCmpDue[d]) begin
                mPass[d] = (mSig[d] == golden(d)) && (mCnt[d] == N);
                mFail[d] = !mPass[d];
                mCmpDue[d] = 0;
                mValid[d] = 1;
            end else if (mValid[d] && ackV[d]) begin
                mValid[d] = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (checkEn) begin
            for (int d = 0; d < ND; d++) begin
                check($sformatf("model sig d%0d", d), int'(dSig[d]), mSig[d]);
                check($sformatf("model cnt d%0d", d), int'(dCnt[d]), mCnt[d]);
                check($sformatf("model busy d%0d", d), int'(dBusy[d]), int'(mCompacting[d] | mCmpDue[d]));
                check($sformatf("model valid d%0d", d), int'(dValid[d]), int'(mValid[d]));
                check($sformatf("model pass d%0d", d), int'(dPass[d]), int'(mPass[d]));
                check($sformatf("model fail d%0d", d), int'(dFail[d]), int'(mFail[d]));
            end
        end
    end

    task automatic drive(input int d, input bit en, input int r, input bit done, input bit ack, input bit clr);
        enV[d] = en; respV[d] = W'(r); doneV[d] = done; ackV[d] = ack; clrV[d] = clr;
    endtask

    task automatic driveAll(input bit en, input int r, input bit done, input bit ack, input bit clr);
        for (int d = 0; d < ND; d++) drive(d, en, r, done, ack, clr);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        rstN = 1'b0;
        driveAll(0, 0, 0, 0, 0);
        tick();
        checkEn = 1'b1;
        check("reset sig", int'(dSig[0]), 0);
        check("reset cnt", int'(dCnt[0]), 0);
        check("reset busy", int'(dBusy[0]), 1);
        check("reset valid", int'(dValid[0]), 0);
        check("reset pass/fail", int'({dPass[0], dFail[0]}), 0);
        rstN = 1'b1;

        driveAll(1, 1, 0, 0, 0);
        tick();
        check("round1 sig", int'(dSig[0]), 4'h1);
        check("round1 cnt", int'(dCnt[0]), 1);
        driveAll(1, 8, 0, 0, 0);
        tick();
        check("round2 sig", int'(dSig[0]), 4'hA);
        drive(0, 1, 0, 0, 0, 0); drive(1, 1, 0, 0, 0, 0); drive(2, 0, 0, 1, 0, 0);
        tick();
        check("round3 sig", int'(dSig[0]), 4'h7);
        check("round3 cnt", int'(dCnt[0]), 3);
        drive(0, 0, 0, 1, 0, 0); drive(1, 0, 0, 1, 0, 0); drive(2, 0, 0, 0, 0, 0);
        tick();
        check("valid not yet", int'(dValid[0]), 0);
        check("short run valid", int'(dValid[2]), 1);
        check("short run fail", int'(dFail[2]), 1);
        check("short run pass", int'(dPass[2]), 0);
        driveAll(0, 0, 1, 0, 0);
        tick();
        check("match valid", int'(dValid[0]), 1);
        check("match pass", int'(dPass[0]), 1);
        check("match fail", int'(dFail[0]), 0);
        check("match busy", int'(dBusy[0]), 0);
        check("mismatch fail", int'(dFail[1]), 1);
        check("mismatch pass", int'(dPass[1]), 0);
        check("mismatch sig", int'(dSig[1]), 4'h7);

        for (int i = 0; i < 10; i++) begin
            drive(0, i == 3, 5, 1, 0, 0);
            tick();
            check("report hold valid", int'(dValid[0]), 1);
            check("report hold pass", int'(dPass[0]), 1);
            check("report frozen sig", int'(dSig[0]), 4'h7);
        end
        drive(0, 0, 0, 1, 1, 0);
        tick();
        drive(0, 0, 0, 1, 0, 0);
        check("ack drops valid", int'(dValid[0]), 0);
        check("ack keeps pass", int'(dPass[0]), 1);
        tick();
        check("hold no recompare", int'(dValid[0]), 0);
        driveAll(1, 9, 1, 1, 1);
        tick();
        check("clear sig", int'(dSig[0]), 0);
        check("clear cnt", int'(dCnt[0]), 0);
        check("clear pass", int'(dPass[0]), 0);
        check("clear busy", int'(dBusy[0]), 1);

        drive(0, 1, 1, 0, 0, 0); tick();
        drive(0, 1, 8, 0, 0, 0); tick();
        drive(0, 1, 0, 1, 0, 0); tick();
        check("same-cycle sig", int'(dSig[0]), 4'h7);
        check("same-cycle cnt", int'(dCnt[0]), 3);
        drive(0, 1, 15, 0, 0, 0); tick();
        check("compare ignores en", int'(dSig[0]), 4'h7);
        drive(0, 0, 0, 0, 0, 0); tick();
        check("same-cycle valid", int'(dValid[0]), 1);
        check("same-cycle pass", int'(dPass[0]), 1);

        driveAll(0, 0, 0, 0, 1); tick();
        driveAll(1, 1, 0, 0, 0); tick();
        driveAll(1, 8, 0, 0, 0); tick();
        rstN = 1'b0;
        driveAll(1, 3, 0, 0, 0);
        tick();
        rstN = 1'b1;
        driveAll(0, 0, 0, 0, 0);
        check("mid reset sig", int'(dSig[0]), 0);
        check("mid reset cnt", int'(dCnt[0]), 0);
        check("mid reset busy", int'(dBusy[0]), 1);

        for (int c = 0; c < 3000; c++) begin
            rstN = ($urandom_range(0, 199) != 0);
            for (int d = 0; d < ND; d++) begin
                drive(d, $urandom_range(0, 1) == 1, int'($urandom_range(0, 15)),
                      $urandom_range(0, 11) == 0, $urandom_range(0, 3) == 0,
                      $urandom_range(0, 39) == 0);
            end
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end
endmodule
